// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs little-endian bytes into 32-bit
// words and writes each one to the instruction memory in a single WRITE cycle.
module imem_loader #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       word_q;
    logic [31:0]       word_d;
    logic              last_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              error_q;
    logic              ready_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic accept;
    logic word_end;

    // ready_q is only ever high in LOAD, so it doubles as the handshake qualifier
    assign accept   = byte_valid & ready_q;
    assign word_end = accept & ((byte_idx_q == 2'd3) | byte_last);
    assign count_d  = count_q + 1'b1;

    always_comb begin
        word_d = word_q;
        case (byte_idx_q)
            2'd0:    word_d[7:0]   = byte_data;
            2'd1:    word_d[15:8]  = byte_data;
            2'd2:    word_d[23:16] = byte_data;
            default: word_d[31:24] = byte_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            last_q     <= 1'b0;
            count_q    <= '0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        byte_idx_q <= 2'd0;
                        word_q     <= 32'd0;
                        last_q     <= 1'b0;
                        count_q    <= '0;
                        error_q    <= 1'b0;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        word_q     <= word_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                    if (word_end) begin
                        state_q <= S_WRITE;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        addr_q  <= count_q[ADDR_W-1:0];
                        wdata_q <= word_d;
                        last_q  <= byte_last;
                    end
                end
                S_WRITE: begin
                    we_q       <= 1'b0;
                    count_q    <= count_d;
                    byte_idx_q <= 2'd0;
                    word_q     <= 32'd0;
                    // an explicit end-of-program wins over running out of memory
                    if (last_q) begin
                        state_q <= S_DONE;
                        error_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (count_d == DEPTH_C) begin
                        state_q <= S_DONE;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = count_q;
    assign error      = error_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, default 8, number of 32-bit words in the target instruction memory.
REQ-002 Parameter: ADDR_W, default 3, width of the word address; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 byte_valid  input  1  byte_data is valid this cycle.
REQ-007 byte_data  input  8  next program byte, little-endian within each word.
REQ-008 byte_last  input  1  qualifies the current byte as the final byte of the program.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  instruction-memory word write enable.
REQ-011 mem_addr  output  ADDR_W  word index being written.
REQ-012 mem_wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  high in LOAD and WRITE states.
REQ-014 done  output  1  high in DONE state.
REQ-015 word_count  output  ADDR_W+1  number of words written in the current session.
REQ-016 error  output  1  program exceeded DEPTH words; valid while done=1.

Function
REQ-017 FSM states: IDLE, LOAD, WRITE, DONE; one state active at a time.
REQ-018 Byte transfer occurs only on a rising edge where byte_valid=1 and byte_ready=1; byte_data and byte_last are ignored otherwise.
REQ-019 byte_ready SHALL be 1 only in LOAD; it is 0 in IDLE, WRITE, DONE.
REQ-020 IDLE: on start=1, clear word_count, byte index, assembly register, error, and the last flag; go to LOAD.
REQ-021 LOAD: accepted byte k (k = 0..3) goes into word bits [8k+7:8k]; byte index increments.
REQ-022 LOAD: when byte index 3 is accepted, or when any byte with byte_last=1 is accepted, go to WRITE next cycle.
REQ-023 Partial word on byte_last: unfilled upper bytes are 0; the last flag is set.
REQ-024 WRITE: for exactly one cycle, mem_we=1, mem_addr=word_count[ADDR_W-1:0], mem_wdata=assembled word.
REQ-025 Latency: mem_we is asserted in the cycle immediately after the word's final byte is accepted; steady throughput is 5 cycles per word.
REQ-026 Leaving WRITE: word_count increments by 1; byte index and assembly register clear.
REQ-027 Leaving WRITE: if the last flag is set, go to DONE with error=0.
REQ-028 Leaving WRITE: else if word_count+1 == DEPTH, go to DONE with error=1.
REQ-029 Leaving WRITE: otherwise return to LOAD.
REQ-030 Overflow boundary: a word that fills the final location with byte_last=1 SHALL give error=0; the last-flag check takes priority over the DEPTH check.
REQ-031 DONE: done=1; word_count and error hold; on start=1, perform the REQ-020 clearing and go to LOAD.
REQ-032 start SHALL be ignored in LOAD and WRITE.
REQ-033 mem_we SHALL never be high outside WRITE; mem_addr SHALL never reach DEPTH.

Reset
REQ-034 reset=1 at a rising edge forces IDLE and sets byte_ready, mem_we, busy, done, error = 0 and word_count = 0; mem_addr and mem_wdata = 0.
REQ-035 reset has priority over start and over any byte transfer in the same cycle.
REQ-036 reset mid-operation aborts the session; no further mem_we occurs, and words already written are not rewritten.

Verification
REQ-037 Full words, DEPTH=8: start, bytes 0x13,0x05,0xA0,0x00 then 0x93,0x05,0x50,0x00 (last on final) -> writes addr0=0x00A00513 and addr1=0x00500593; done=1, word_count=2, error=0.
REQ-038 Partial word: start, bytes 0xEF,0xBE with byte_last on 0xBE -> a single write of addr0=0x0000BEEF the next cycle; word_count=1, error=0.
REQ-039 Overflow, DEPTH=2: send 12 bytes with no byte_last -> 2 writes (addr0, addr1); done=1, error=1; byte_ready=0 after the second write, and bytes 9-12 are not accepted.
REQ-040 Backpressure and gaps: random byte_valid gaps, start pulsed during LOAD -> same words as gap-free run; start has no effect; mem_we occurs only for 1 cycle per word.
REQ-041 Reset mid-session: reset after 2 bytes of word 1 -> next cycle IDLE, all outputs 0; a new start reloads from addr0.
REQ-042 Exact fill, DEPTH=2: 8 bytes with byte_last on the 8th -> 2 writes, error=0, word_count=2.
